// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the AES block sequencer.
package aes_seq_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/aes_seq_fifo.sv
// DEPTH x 128-bit synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module aes_seq_fifo
    import aes_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [AES_BLK_W-1:0] i_wdata,
    input  logic                 i_pop,
    output logic [AES_BLK_W-1:0] o_rdata,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    aes_blk_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Streaming ECB/CBC front-end that drives one aes_top core through its START/DONE handshake.
// Optional watchdog on the core response: define AES_SEQ_TIMEOUT_EN.
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter logic        CORE_ENC_VAL   = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 cfg_load,
    input  logic [AES_BLK_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 cfg_cbc,
    input  logic                 cfg_dec,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy,
    output logic                 err,
    output logic                 core_start,
    output logic                 core_encdec,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_textin,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_textout
);

    seq_state_t r_state;
    aes_blk_t   r_key;
    aes_blk_t   r_chain;
    aes_blk_t   r_blk_q;
    aes_blk_t   r_core_textin;
    aes_blk_t   r_out_data;
    logic       r_cbc;
    logic       r_dec;
    logic       r_core_start;
    logic       r_core_encdec;
    logic       r_out_valid;

    logic       w_fifo_full;
    logic       w_fifo_empty;
    aes_blk_t   w_fifo_head;
    logic       w_push;
    logic       w_pop;
    logic       w_busy;
    logic       w_cfg_take;
    aes_blk_t   w_core_in;
    aes_blk_t   w_result;

    assign w_push     = in_valid & ~w_fifo_full;
    assign w_pop      = (r_state == ISSUE);
    assign w_busy     = ~w_fifo_empty | (r_state != IDLE) | r_out_valid;
    assign w_cfg_take = cfg_load & ~w_busy;

    // Chaining XORs sit in front of the request/result registers.
    assign w_core_in  = (r_cbc & ~r_dec) ? (w_fifo_head ^ r_chain) : w_fifo_head;
    assign w_result   = (r_cbc &  r_dec) ? (core_textout ^ r_chain) : core_textout;

    aes_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_state == WAIT) && !core_done && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != WAIT) r_tmo_cnt <= '0;
            else                 r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_tmo_hit)       r_err <= 1'b1;
            else if (w_cfg_take) r_err <= 1'b0;
        end
    end
`else
    logic w_tmo_hit;
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign err          = 1'b0;
`endif

    // Sequencer FSM plus the configuration, chain and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= IDLE;
            r_key         <= '0;
            r_chain       <= '0;
            r_blk_q       <= '0;
            r_core_textin <= '0;
            r_out_data    <= '0;
            r_cbc         <= 1'b0;
            r_dec         <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_encdec <= CORE_ENC_VAL;
            r_out_valid   <= 1'b0;
        end else begin
            if (w_cfg_take) begin
                r_key         <= cfg_key;
                r_chain       <= cfg_iv;
                r_cbc         <= cfg_cbc;
                r_dec         <= cfg_dec;
                r_core_encdec <= cfg_dec ? ~CORE_ENC_VAL : CORE_ENC_VAL;
            end
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty && !r_out_valid) begin
                        r_state       <= ISSUE;
                        r_core_start  <= 1'b1;
                        r_core_textin <= w_core_in;
                        r_blk_q       <= w_fifo_head;
                    end
                end
                ISSUE: begin
                    r_core_start <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        if (r_cbc) r_chain <= r_dec ? r_blk_q : core_textout;
                        r_state     <= IDLE;
                    end else if (w_tmo_hit) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = ~w_fifo_full;
    assign busy        = w_busy;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign core_start  = r_core_start;
    assign core_encdec = r_core_encdec;
    assign core_key    = r_key;
    assign core_textin = r_core_textin;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer with a table-driven stand-in for the AES core.
module tb_aes_block_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PB  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CA  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CB  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] XA  = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] XB  = 128'hd86421fb9f1a1eda505ee1375746972c;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         cfg_load;
    logic [127:0] cfg_key, cfg_iv;
    logic         cfg_cbc, cfg_dec;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         busy, err;
    logic         core_start, core_encdec, core_done;
    logic [127:0] core_key, core_textin, core_textout;

    aes_block_sequencer #(
        .DEPTH          (DEPTH),
        .CORE_ENC_VAL   (1'b1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .cfg_load     (cfg_load),
        .cfg_key      (cfg_key),
        .cfg_iv       (cfg_iv),
        .cfg_cbc      (cfg_cbc),
        .cfg_dec      (cfg_dec),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .err          (err),
        .core_start   (core_start),
        .core_encdec  (core_encdec),
        .core_key     (core_key),
        .core_textin  (core_textin),
        .core_done    (core_done),
        .core_textout (core_textout)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         enc;
        logic [127:0] key;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         tbl [6];
    logic [127:0] exp_q [$];
    int           checks    = 0;
    int           failures  = 0;
    int           n_starts  = 0;
    int           core_lat  = 3;
    bit           core_hold = 1'b0;
    logic [127:0] core_r;

    // Known AES vectors; anything else gets a cheap keyed swap so other traffic is still traceable.
    function automatic logic [127:0] core_fn(input logic enc, input logic [127:0] key, input logic [127:0] din);
        for (int i = 0; i < 6; i++)
            if (tbl[i].enc == enc && tbl[i].key == key && tbl[i].din == din) return tbl[i].dout;
        return {din[63:0], din[127:64]} ^ key ^ {128{enc}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},    128'(in_ready),    128'd1);
        check({tag, "_out_valid"},   128'(out_valid),   128'd0);
        check({tag, "_out_data"},    out_data,          128'd0);
        check({tag, "_core_start"},  128'(core_start),  128'd0);
        check({tag, "_core_textin"}, core_textin,       128'd0);
        check({tag, "_core_key"},    core_key,          128'd0);
        check({tag, "_core_encdec"}, 128'(core_encdec), 128'd1);
        check({tag, "_busy"},        128'(busy),        128'd0);
        check({tag, "_err"},         128'(err),         128'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin @(posedge CLK); #1; n++; end
        if (busy) check("idle_timeout", 128'(busy), 128'd0);
    endtask

    task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv, input logic cbc, input logic dec);
        wait_idle();
        cfg_key = key; cfg_iv = iv; cfg_cbc = cbc; cfg_dec = dec; cfg_load = 1'b1;
        @(posedge CLK); #1;
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [127:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 500) begin @(posedge CLK); #1; n++; end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin @(posedge CLK); #1; n++; end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
    endtask

    // Core stand-in: sees START, answers with one DONE pulse core_lat edges later.
    initial begin
        core_done    = 1'b0;
        core_textout = '0;
        forever begin
            @(negedge CLK);
            if (nRST && core_start) begin
                core_r = core_fn(core_encdec == 1'b1, core_key, core_textin);
                repeat (core_lat) @(posedge CLK);
                #1;
                if (!core_hold && nRST) begin
                    core_textout = core_r;
                    core_done    = 1'b1;
                    @(posedge CLK); #1;
                    core_done    = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST && core_start) n_starts++;
    end

    // Scoreboard monitor: compare every completed output handshake against the queue head.
    always @(negedge CLK) begin
        if (nRST && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_unexpected", 128'(out_valid), 128'd0);
            else                   check("out_data", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [127:0] blk;

        tbl[0] = '{1'b1, K1, P1, C1};
        tbl[1] = '{1'b0, K1, C1, P1};
        tbl[2] = '{1'b1, K2, XA, CA};
        tbl[3] = '{1'b1, K2, XB, CB};
        tbl[4] = '{1'b0, K2, CA, XA};
        tbl[5] = '{1'b0, K2, CB, XB};

        nRST = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0; cfg_dec = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        nRST = 1'b1;
        @(posedge CLK); #1;
        check_reset_vals("post_rst");

        // ECB encrypt, including request latency and core inputs.
        do_cfg(K1, '0, 1'b0, 1'b0);
        check("ecb_enc_key", core_key, K1);
        check("ecb_enc_encdec", 128'(core_encdec), 128'd1);
        exp_q.push_back(C1);
        send(P1);
        check("start_early", 128'(core_start), 128'd0);
        @(posedge CLK); #1;
        check("start_latency", 128'(core_start), 128'd1);
        check("ecb_textin", core_textin, P1);
        drain();

        // ECB decrypt.
        do_cfg(K1, '0, 1'b0, 1'b1);
        check("ecb_dec_encdec", 128'(core_encdec), 128'd0);
        exp_q.push_back(P1);
        send(C1);
        drain();

        // CBC encrypt then decrypt, two chained blocks each.
        do_cfg(K2, IV2, 1'b1, 1'b0);
        exp_q.push_back(CA);
        exp_q.push_back(CB);
        send(PA);
        send(PB);
        drain();
        do_cfg(K2, IV2, 1'b1, 1'b1);
        exp_q.push_back(PA);
        exp_q.push_back(PB);
        send(CA);
        send(CB);
        drain();

        // Back-pressure: DEPTH+1 blocks with the consumer stalled.
        do_cfg(K1, '0, 1'b0, 1'b0);
        out_ready = 1'b0;
        s0 = n_starts;
        for (int k = 0; k <= DEPTH; k++) begin
            blk = {4{32'hA5A50000 + 32'(k)}};
            exp_q.push_back(core_fn(1'b1, K1, blk));
            send(blk);
        end
        check("fill_in_ready", 128'(in_ready), 128'd0);
        repeat (20) @(posedge CLK);
        #1;
        check("fill_one_start", 128'(n_starts - s0), 128'd1);
        check("fill_out_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        drain();
        check("fill_all_starts", 128'(n_starts - s0), 128'(DEPTH + 1));

        // Reset while the core is busy; a late DONE must be ignored.
        core_hold = 1'b1;
        send(P1 ^ 128'h1);
        send(P1 ^ 128'h2);
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge CLK); #1;
        nRST = 1'b1;
        core_hold = 1'b0;
        @(posedge CLK); #1;
        core_textout = 128'hdeadbeef_00000000_cafef00d_12345678;
        core_done    = 1'b1;
        @(posedge CLK); #1;
        core_done    = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("late_done_out_valid", 128'(out_valid), 128'd0);
        check("late_done_busy", 128'(busy), 128'd0);
        check("late_done_in_ready", 128'(in_ready), 128'd1);

`ifdef AES_SEQ_TIMEOUT_EN
        // Watchdog: withhold DONE, then recover and clear the flag.
        do_cfg(K1, '0, 1'b0, 1'b0);
        core_hold = 1'b1;
        send(P1);
        begin
            int n = 0;
            while (!err && n < 4 * TMO) begin @(posedge CLK); #1; n++; end
        end
        check("tmo_err", 128'(err), 128'd1);
        @(posedge CLK); #1;
        check("tmo_idle", 128'(busy), 128'd0);
        core_hold = 1'b0;
        exp_q.push_back(C1);
        send(P1);
        drain();
        check("tmo_err_sticky", 128'(err), 128'd1);
        do_cfg(K1, '0, 1'b0, 1'b0);
        check("tmo_err_clear", 128'(err), 128'd0);
`else
        exp_q.push_back(C1);
        do_cfg(K1, '0, 1'b0, 1'b0);
        send(P1);
        drain();
        check("err_tied", 128'(err), 128'd0);
`endif

        repeat (5) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
